// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - memory-mapped UART transmitter with byte FIFO and programmable divisor
//
// Ports:
//   clk    in   1  system clock
//   reset  in   1  synchronous active-high reset
//   sel    in   1  bus select
//   we     in   1  write strobe, qualified by sel
//   addr   in   2  register index (0 DATA, 1 STATUS, 2 DIV, 3 reserved)
//   wdata  in  32  write data
//   rdata  out 32  registered read data, updated on every sel & !we cycle
//   txd    out  1  serial output, idle high, driven from a flop
//   busy   out  1  frame in progress or FIFO non-empty
module uart_tx_ctrl #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        txd,
    output logic        busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int DIV_RAW = CLK_HZ / BAUD;
    localparam logic [15:0] DIV_RST = (DIV_RAW < 2) ? 16'd2 : 16'(DIV_RAW);

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_DIV    = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // FIFO storage and pointers; pointers wrap naturally because DEPTH is a power of two
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Register file
    logic [15:0]   div_q;
    logic          overflow_q;
    logic [31:0]   rdata_q;

    // Transmit FSM
    state_t        state_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_idx_q;
    logic [15:0]   baud_cnt_q;
    logic [15:0]   frame_div_q;
    logic          txd_q;

    logic          full;
    logic          empty;
    logic          data_wr;
    logic          push;
    logic          pop;
    logic [31:0]   count_ext;
    logic [2:0]    count_sat;
    logic [31:0]   status_word;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign data_wr = sel && we && (addr == A_DATA);
    assign push    = data_wr && !full;
    // The FSM takes the head the same cycle it leaves IDLE
    assign pop     = (state_q == S_IDLE) && !empty;

    assign count_ext   = 32'(count_q);
    assign count_sat   = (count_ext > 32'd7) ? 3'd7 : count_ext[2:0];
    assign status_word = {25'd0, count_sat, overflow_q, (state_q != S_IDLE), empty, full};

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // FIFO data array carries no reset; emptiness is tracked by count_q alone
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    // Bus registers: divisor, sticky overflow, registered read data
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q      <= DIV_RST;
            overflow_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (sel && we && (addr == A_DIV)) begin
                div_q <= (wdata[15:0] < 16'd2) ? 16'd2 : wdata[15:0];
            end

            if (data_wr && full) begin
                overflow_q <= 1'b1;
            end else if (sel && we && (addr == A_STATUS)) begin
                overflow_q <= 1'b0;
            end

            if (sel && !we) begin
                case (addr)
                    A_STATUS: rdata_q <= status_word;
                    A_DIV:    rdata_q <= {16'd0, div_q};
                    default:  rdata_q <= '0;
                endcase
            end
        end
    end

    // Frame sequencer. frame_div_q is latched at frame start so DIV writes
    // only take effect on the following frame. txd_q is loaded with the level
    // of the state being entered so the pin changes on the same edge as state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            baud_cnt_q  <= '0;
            frame_div_q <= DIV_RST;
            txd_q       <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    txd_q <= 1'b1;
                    if (!empty) begin
                        shift_q     <= mem_q[rd_ptr_q];
                        frame_div_q <= div_q;
                        baud_cnt_q  <= div_q - 16'd1;
                        bit_idx_q   <= '0;
                        txd_q       <= 1'b0;
                        state_q     <= S_START;
                    end
                end

                S_START: begin
                    if (baud_cnt_q == 16'd0) begin
                        baud_cnt_q <= frame_div_q - 16'd1;
                        bit_idx_q  <= '0;
                        txd_q      <= shift_q[0];
                        state_q    <= S_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end

                S_DATA: begin
                    if (baud_cnt_q == 16'd0) begin
                        baud_cnt_q <= frame_div_q - 16'd1;
                        if (bit_idx_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            shift_q   <= {1'b0, shift_q[7:1]};
                            bit_idx_q <= bit_idx_q + 3'd1;
                            txd_q     <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end

                S_STOP: begin
                    if (baud_cnt_q == 16'd0) begin
                        txd_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end

                default: begin
                    txd_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rdata = rdata_q;
    assign txd   = txd_q;
    assign busy  = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - directed self-checking bench for uart_tx_ctrl
module tb_uart_tx_ctrl;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        txd;
    logic        busy;

    int tests;
    int fails;

    uart_tx_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .txd   (txd),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        sel = 1'b0;
        d = rdata;
    endtask

    // Waits (bounded) for the start bit, reporting idle negedges seen before it,
    // then checks every cycle of all ten bit periods against the expected frame.
    task automatic check_frame(input logic [7:0] exp, input int div, input int max_wait,
                               output int idle, input string name);
        int bad;
        logic exp_bit;
        logic got_bit;
        logic want_bit;
        idle = 0;
        bad = 0;
        got_bit = 1'b0;
        want_bit = 1'b0;
        @(negedge clk);
        while (txd !== 1'b0 && idle < max_wait) begin
            idle++;
            @(negedge clk);
        end
        tests++;
        if (txd !== 1'b0) begin
            fails++;
            $display("FAIL %s_start: txd=%b after %0d cycles, required 0", name, txd, idle);
            return;
        end
        for (int b = 0; b < 10; b++) begin
            exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp[b-1];
            for (int c = 0; c < div; c++) begin
                if (!(b == 0 && c == 0)) @(negedge clk);
                if (txd !== exp_bit) begin
                    if (bad == 0) begin
                        got_bit = txd;
                        want_bit = exp_bit;
                    end
                    bad++;
                end
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s_bits: %0d bad cycles, first txd=%b required %b (byte %02h div %0d)",
                     name, bad, got_bit, want_bit, exp, div);
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        tests++;
        if (txd !== 1'b1 || busy !== 1'b0 || rdata !== 32'd0) begin
            fails++;
            $display("FAIL reset_outputs: txd=%b busy=%b rdata=%08h required 1 0 00000000", txd, busy, rdata);
        end
        bus_read(2'd1, d);
        tests++;
        if (d !== 32'h2) begin
            fails++;
            $display("FAIL reset_status: got %08h required 00000002", d);
        end
        bus_read(2'd0, d);
        tests++;
        if (d !== 32'h0) begin
            fails++;
            $display("FAIL read_addr0: got %08h required 00000000", d);
        end
        bus_read(2'd3, d);
        tests++;
        if (d !== 32'h0) begin
            fails++;
            $display("FAIL read_addr3: got %08h required 00000000", d);
        end
        bus_read(2'd2, d);
        tests++;
        if (d !== 32'd434) begin
            fails++;
            $display("FAIL reset_div: got %0d required 434", d);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (rdata !== 32'd434) begin
            fails++;
            $display("FAIL rdata_hold: got %0d required 434", rdata);
        end
    endtask

    task automatic test_div_reg;
        logic [31:0] d;
        bus_write(2'd2, 32'd1);
        bus_read(2'd2, d);
        tests++;
        if (d !== 32'd2) begin
            fails++;
            $display("FAIL div_clamp: got %0d required 2", d);
        end
        bus_write(2'd2, 32'h12345);
        bus_read(2'd2, d);
        tests++;
        if (d !== 32'h2345) begin
            fails++;
            $display("FAIL div_trunc: got %08h required 00002345", d);
        end
        bus_write(2'd3, 32'hFFFF);
        bus_read(2'd2, d);
        tests++;
        if (d !== 32'h2345) begin
            fails++;
            $display("FAIL reserved_write: DIV got %08h required 00002345", d);
        end
    endtask

    task automatic test_single_frame;
        int idle;
        logic [31:0] d;
        bus_write(2'd2, 32'd4);
        bus_write(2'd0, 32'h55);
        tests++;
        if (txd !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL push_state: txd=%b busy=%b required 1 1", txd, busy);
        end
        check_frame(8'h55, 4, 20, idle, "frame55");
        tests++;
        if (idle != 0) begin
            fails++;
            $display("FAIL start_latency: idle cycles %0d required 0", idle);
        end
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_in_stop: got %b required 1", busy);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || txd !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_stop: busy=%b txd=%b required 0 1", busy, txd);
        end
        bus_read(2'd1, d);
        tests++;
        if (d !== 32'h2) begin
            fails++;
            $display("FAIL status_after_frame: got %08h required 00000002", d);
        end
    endtask

    task automatic test_back_to_back;
        int idle;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [7:0] bytes [5];
        bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03; bytes[3] = 8'h04; bytes[4] = 8'h05;
        fork
            begin
                // six writes on consecutive edges: first pops immediately, sixth hits a full FIFO
                for (int i = 1; i <= 6; i++) begin
                    @(negedge clk);
                    sel = 1'b1; we = 1'b1; addr = 2'd0; wdata = 32'(i);
                end
                @(negedge clk);
                sel = 1'b0; we = 1'b0;
                bus_read(2'd1, d1);
                tests++;
                if (d1 !== 32'h4D) begin
                    fails++;
                    $display("FAIL overflow_status: got %08h required 0000004d", d1);
                end
                bus_write(2'd1, 32'h0);
                bus_read(2'd1, d2);
                tests++;
                if (d2 !== 32'h45) begin
                    fails++;
                    $display("FAIL overflow_clear: got %08h required 00000045", d2);
                end
            end
            begin
                check_frame(bytes[0], 4, 20, idle, "b2b_0");
                for (int i = 1; i < 5; i++) begin
                    check_frame(bytes[i], 4, 5, idle, "b2b");
                    tests++;
                    if (idle != 1) begin
                        fails++;
                        $display("FAIL b2b_gap: frame %0d idle cycles %0d required 1", i, idle);
                    end
                end
            end
        join
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain: busy=%b required 0", busy);
        end
    endtask

    task automatic test_div_midframe;
        int idle;
        int idle2;
        bus_write(2'd2, 32'd8);
        fork
            begin
                bus_write(2'd0, 32'hC3);
                bus_write(2'd0, 32'h3C);
                repeat (20) @(negedge clk);
                bus_write(2'd2, 32'd4);
            end
            begin
                check_frame(8'hC3, 8, 20, idle, "div8_frame");
                check_frame(8'h3C, 4, 5, idle2, "div4_frame");
                tests++;
                if (idle2 != 1) begin
                    fails++;
                    $display("FAIL div_gap: idle cycles %0d required 1", idle2);
                end
            end
        join
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midframe;
        logic [31:0] d;
        int lows;
        bus_write(2'd0, 32'hA5);
        bus_write(2'd0, 32'h11);
        bus_write(2'd0, 32'h22);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_midframe: txd=%b busy=%b required 1 0", txd, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        bus_read(2'd1, d);
        tests++;
        if (d !== 32'h2) begin
            fails++;
            $display("FAIL status_after_reset: got %08h required 00000002", d);
        end
        bus_read(2'd2, d);
        tests++;
        if (d !== 32'd434) begin
            fails++;
            $display("FAIL div_after_reset: got %0d required 434", d);
        end
        lows = 0;
        repeat (30) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        tests++;
        if (lows != 0) begin
            fails++;
            $display("FAIL flushed_idle: txd low for %0d cycles required 0", lows);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        sel = 1'b0;
        we = 1'b0;
        addr = 2'd0;
        wdata = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset;
        test_div_reg;
        test_single_frame;
        test_back_to_back;
        test_div_midframe;
        test_reset_midframe;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
